// File: rtl/key_insn_injector.sv
// Front-panel key injector: synchronises and debounces N active-low buttons and turns each
// press (or auto-repeat tick) into one programmable instruction word behind a fetch stall.
module key_insn_injector #(
  parameter int NUM_KEYS        = 3,
  parameter int INSN_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 3,
  parameter int REPEAT_CYCLES   = 0,
  localparam int ID_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                           clk_in,
  input  logic                           clrn,
  input  logic [NUM_KEYS-1:0]            keys_n,
  input  logic [NUM_KEYS*INSN_WIDTH-1:0] key_insns,
  output logic [INSN_WIDTH-1:0]          insn_key,
  output logic                           key_pressed_out,
  output logic [ID_W-1:0]                key_id
);

  localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_W     = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int HOLD_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES - 1) : 1;
  localparam int HOLD_LAST = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] press_evt;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                take;
  logic                any_pend;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     svc_id;

  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic                  kpo_q, kpo_d;
  logic [ID_W-1:0]       id_q, id_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [DB_W-1:0] db_q, db_d;
      logic            deb_nx;
      logic            rep_evt;

      // Any sample that agrees with the debounced state restarts the stability count.
      always_comb begin
        db_d   = '0;
        deb_nx = deb_q[gi];
        if (~sync2_q[gi] != deb_q[gi]) begin
          if (db_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_nx = ~deb_q[gi];
          end else begin
            db_d = db_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_in) begin
        if (!clrn) begin
          db_q <= '0;
        end else begin
          db_q <= db_d;
        end
      end

      assign deb_d[gi] = deb_nx;

      if (REPEAT_CYCLES > 0) begin : g_rep
        logic [REP_W-1:0] rep_q, rep_d;
        logic             held;

        assign held    = deb_q[gi] & deb_nx;
        assign rep_evt = held && (rep_q == REP_W'(REPEAT_CYCLES - 1));

        always_comb begin
          rep_d = '0;
          if (held && !rep_evt) begin
            rep_d = rep_q + 1'b1;
          end
        end

        always_ff @(posedge clk_in) begin
          if (!clrn) begin
            rep_q <= '0;
          end else begin
            rep_q <= rep_d;
          end
        end
      end else begin : g_norep
        assign rep_evt = 1'b0;
      end

      assign press_evt[gi] = (deb_nx & ~deb_q[gi]) | rep_evt;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!clrn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= keys_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
    end
  end

  // Highest pending index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pend_q[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  assign any_pend = |pend_q;

  always_comb begin
    pend_d = pend_q;
    if (take) begin
      pend_d[win_id] = 1'b0;
    end
    pend_d = pend_d | press_evt;
  end

  always_ff @(posedge clk_in) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      insn_q  <= '0;
      kpo_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      insn_q  <= insn_d;
      kpo_q   <= kpo_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          take    = 1'b1;
          hold_d  = '0;
          state_d = (HOLD_CYCLES == 1) ? S_ISSUE : S_STALL;
        end
      end
      S_STALL: begin
        if (hold_q == HOLD_W'(HOLD_LAST)) begin
          state_d = S_ISSUE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state, so the word is sampled on the edge entering ISSUE.
  always_comb begin
    svc_id = take ? win_id : id_q;
    kpo_d  = (state_d != S_IDLE);
    id_d   = kpo_d ? svc_id : '0;
    insn_d = '0;
    if (state_d == S_ISSUE) begin
      insn_d = key_insns[int'(svc_id)*INSN_WIDTH +: INSN_WIDTH];
    end
  end

  assign insn_key        = insn_q;
  assign key_pressed_out = kpo_q;
  assign key_id          = id_q;

endmodule

// File: doc/key_insn_injector.md
Name: key_insn_injector

Overview:
- Parametrised successor to the front-panel key block: converts N active-low push-buttons into one-shot instruction words injected into the processor fetch path.
- Adds per-key synchronisation and debounce, fixed priority, a pending queue for presses during a busy window, programmable instruction words, a configurable stall length and optional auto-repeat.
- Outputs NOP (all zeros) whenever no instruction is being injected, and raises key_pressed_out for the whole stall window so the pipeline freezes normal fetch.

Parameters:
NUM_KEYS, 3, number of button inputs (1..8)
INSN_WIDTH, 32, instruction word width
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to change a key's debounced state (>=1)
HOLD_CYCLES, 3, stall window length in cycles; the instruction is driven on the last cycle (>=1)
REPEAT_CYCLES, 0, auto-repeat period while a key is held; 0 disables auto-repeat (otherwise >= HOLD_CYCLES+1)

Ports:
clk_in  input  1  system clock; all state changes on rising edge
clrn  input  1  reset; synchronous, active-low
keys_n  input  NUM_KEYS  raw buttons, active-low, asynchronous to clk_in
key_insns  input  NUM_KEYS*INSN_WIDTH  instruction word for key i in bits [i*INSN_WIDTH +: INSN_WIDTH]; quasi-static
insn_key  output  INSN_WIDTH  injected instruction; zero when not issuing
key_pressed_out  output  1  stall request, high for the entire window
key_id  output  max(1,clog2(NUM_KEYS))  index of the key being serviced; valid while key_pressed_out=1, 0 otherwise

Behaviour:
- Reset: clrn is synchronous, active-low. When clrn=0 at a clock edge: sync flops := 1 (released), debounced state := 0, all counters := 0, pending := 0, FSM := IDLE, insn_key := 0, key_pressed_out := 0, key_id := 0. Reset asserted mid-window aborts the window; no instruction is issued and pending presses are discarded.
- Sync: each keys_n bit passes through two flops; pressed_sync = ~second stage.
- Debounce: per-key counter. When pressed_sync differs from the debounced state, the counter increments. The debounced state flips on the edge where the counter reaches DEBOUNCE_CYCLES. A matching sample clears the counter, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press event: a debounced 0->1 transition sets pending[i]. The pending bit is one deep per key; further events for a key that is already pending are dropped. Release events are ignored.
- Auto-repeat (REPEAT_CYCLES>0): per-key repeat counter runs while the debounced state is 1 and resets on release. Each time it reaches REPEAT_CYCLES it sets pending[i] again.
- Priority: when several keys are pending, the highest index wins. Lower-index pending bits are serviced in later windows.
- FSM:
  - IDLE: insn_key=0, key_pressed_out=0. If any pending bit is set, capture the winner into key_id, clear its pending bit, go to STALL (or ISSUE if HOLD_CYCLES=1).
  - STALL: key_pressed_out=1, insn_key=0. Count HOLD_CYCLES-1 cycles, then go to ISSUE.
  - ISSUE: key_pressed_out=1, insn_key=key_insns[key_id]. One cycle, then go to IDLE.
- At least one IDLE cycle always separates windows (NOP with stall low), so back-to-back pending keys are spaced HOLD_CYCLES+1 cycles apart.
- All outputs are registered, with no combinational path from keys_n or key_insns to any output. key_insns is sampled in the cycle before ISSUE.
- Latency: if keys_n[i] is first sampled low at edge 0 and held, key_pressed_out is high after edge 2+DEBOUNCE_CYCLES. insn_key is valid during the cycle after edge 1+DEBOUNCE_CYCLES+HOLD_CYCLES. With the defaults, stall is high after edges 6, 7 and 8, and the instruction is present in the cycle after edge 8.
- A press that arrives during a window becomes pending and is serviced after the mandatory IDLE cycle. Holding a key with REPEAT_CYCLES=0 issues exactly once per press.

Test Plan:
1. Defaults; key_insns[2]=0x0800005A; hold keys_n=3'b011 for 20 cycles -> key_pressed_out high for exactly 3 cycles starting after edge 6; insn_key=0x0800005A only in the third; key_id=2; then zeros, no second issue.
2. Bounce: pulse keys_n[0] low for 3 cycles, high 1, low 3 -> no window ever opens. Then hold low 10 cycles -> exactly one window with key_insns[0].
3. Simultaneous: keys_n goes from 3'b111 to 3'b000 in one cycle -> windows for key 2, 1, 0 in that order; each window is 3 cycles with stall high, separated by one idle cycle; each issues its own word.
4. Auto-repeat: REPEAT_CYCLES=8; hold key 1 for 40 cycles after debounce -> windows start every 8 cycles (5 windows total); release -> no further windows.
5. Reset mid-window: press key 0, drive clrn=0 during the second STALL cycle -> next edge all outputs 0; after release, no instruction is issued.
6. HOLD_CYCLES=1, NUM_KEYS=5, INSN_WIDTH=16 -> stall is a single cycle carrying the instruction; key_id for key 4 is 3'd4.
